// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package demux_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT,
        FILL
    } state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/demux_1to4_tdm_if.sv
// Framed sample stream in, four-channel frame out with valid/ready.
interface demux_1to4_tdm_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;

    // Producer of samples / consumer of frames
    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  out_valid, out0, out1, out2, out3
    );

    // The demultiplexer itself
    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output out_valid, out0, out1, out2, out3
    );

endinterface

// File: rtl/demux_frame_buf.sv
// Output frame holding registers with valid/ready; reports whether a new frame can load.
module demux_frame_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic [WIDTH-1:0] s3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             can_load
);

    // A slot frees up either when empty or when the consumer drains it this cycle
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out0      <= s0;
            out1      <= s1;
            out2      <= s2;
            out3      <= s3;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4_tdm.sv
// Time-division 1-to-4 demultiplexer: assembles sof-aligned 4-slot frames for four channels.
// Optional build macro DEMUX_ERR_CNT_EN adds a saturating 8-bit error counter output err_cnt.
module demux_1to4_tdm
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    demux_1to4_tdm_if.slave   bus,
    output logic [SLOT_W-1:0] slot,
    output logic              err_sync,
`ifdef DEMUX_ERR_CNT_EN
    output logic              err_ovf,
    output logic [7:0]        err_cnt
`else
    output logic              err_ovf
`endif
);

    state_t             state_q, state_d;
    slot_t              slot_q, slot_d;
    logic [WIDTH-1:0]   shadow_q [SLOTS-1];
    logic               wr_en;
    slot_t              wr_idx;
    logic               sync_d;
    logic               complete;
    logic               can_load;
    logic               load;
    logic               ovf_d;

    assign slot = slot_q;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        wr_en    = 1'b0;
        wr_idx   = slot_q;
        sync_d   = 1'b0;
        complete = 1'b0;
        case (state_q)
            HUNT: begin
                if (bus.in_valid && bus.in_sof) begin
                    state_d = FILL;
                    slot_d  = 2'd1;
                    wr_en   = 1'b1;
                    wr_idx  = 2'd0;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        // Early sof: restart the frame from this sample
                        sync_d = 1'b1;
                        slot_d = 2'd1;
                        wr_en  = 1'b1;
                        wr_idx = 2'd0;
                    end else if (slot_q == 2'(SLOTS - 1)) begin
                        complete = 1'b1;
                        slot_d   = 2'd0;
                        state_d  = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
        endcase
    end

    // Slot 3 bypasses the shadow and goes straight into the output registers
    assign load  = complete && can_load;
    assign ovf_d = complete && !can_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            err_sync <= 1'b0;
            err_ovf  <= 1'b0;
            for (int i = 0; i < SLOTS - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            err_sync <= sync_d;
            err_ovf  <= ovf_d;
            if (wr_en) begin
                shadow_q[wr_idx] <= bus.in_data;
            end
        end
    end

    demux_frame_buf #(
        .WIDTH(WIDTH)
    ) u_frame_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .s0       (shadow_q[0]),
        .s1       (shadow_q[1]),
        .s2       (shadow_q[2]),
        .s3       (bus.in_data),
        .out_ready(bus.out_ready),
        .out_valid(bus.out_valid),
        .out0     (bus.out0),
        .out1     (bus.out1),
        .out2     (bus.out2),
        .out3     (bus.out3),
        .can_load (can_load)
    );

`ifdef DEMUX_ERR_CNT_EN
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Counter steps on the same edge that raises the error pulse(s)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= sat_add(err_cnt, {1'b0, sync_d} + {1'b0, ovf_d});
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Directed bench for demux_1to4_tdm: scoreboard of expected frames, checked at each handshake.
module tb_demux_1to4_tdm;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] slot;
    logic       err_sync;
    logic       err_ovf;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         exp_cnt = 0;
`endif

    logic [31:0] sb [$];
    int          ncmp  = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    demux_1to4_tdm_if #(.WIDTH(8)) bus ();

    demux_1to4_tdm #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .slot    (slot),
        .err_sync(err_sync),
`ifdef DEMUX_ERR_CNT_EN
        .err_ovf (err_ovf),
        .err_cnt (err_cnt)
`else
        .err_ovf (err_ovf)
`endif
    );

    function automatic logic [31:0] outs();
        return {bus.out0, bus.out1, bus.out2, bus.out3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle; retire a frame if a handshake happens on this edge
    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic es, input logic eo);
        logic [31:0] f;
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                f = sb.pop_front();
                chk("frame", outs(), f);
            end
        end
        @(posedge clk);
        #1;
        chk("err_sync", 32'(err_sync), 32'(es));
        chk("err_ovf", 32'(err_ovf), 32'(eo));
`ifdef DEMUX_ERR_CNT_EN
        if (es) exp_cnt++;
        if (eo) exp_cnt++;
        chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [31:0] f, input logic push, input logic eo_last);
        drive(1'b1, 1'b1, f[31:24], 1'b0, 1'b0);
        drive(1'b1, 1'b0, f[23:16], 1'b0, 1'b0);
        drive(1'b1, 1'b0, f[15:8],  1'b0, 1'b0);
        if (push) sb.push_back(f);
        drive(1'b1, 1'b0, f[7:0],   1'b0, eo_last);
    endtask

    initial begin
        logic [31:0] f;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_outs", outs(), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_err", 32'({err_sync, err_ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame with consumer always ready
        drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("slot_after_sof", 32'(slot), 32'd1);
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        sb.push_back(32'h11223344);
        drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        idle();
        chk("basic_drop", 32'(bus.out_valid), 32'd0);

        // Samples without sof while hunting are ignored
        drive(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        chk("hunt_slot", 32'(slot), 32'd0);
        chk("hunt_valid", 32'(bus.out_valid), 32'd0);

        // Early sof aborts the partial frame
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        chk("partial_slot", 32'(slot), 32'd2);
        drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        chk("resync_slot", 32'(slot), 32'd1);
        drive(1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
        sb.push_back(32'h10203040);
        drive(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        chk("resync_valid", 32'(bus.out_valid), 32'd1);
        idle();

        // Overflow: consumer stalled, second frame dropped
        bus.out_ready = 1'b0;
        send_frame(32'hA1A2A3A4, 1'b1, 1'b0);
        chk("ovf_first", outs(), 32'hA1A2A3A4);
        send_frame(32'hB1B2B3B4, 1'b0, 1'b1);
        chk("ovf_held", outs(), 32'hA1A2A3A4);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        idle();
        chk("ovf_drain", 32'(bus.out_valid), 32'd0);

        // Full-rate frames, each drained before the next completes
        for (int k = 0; k < 3; k++) begin
            f = 32'hC1C2C3C4 + 32'(k) * 32'h01010101;
            drive(1'b1, 1'b1, f[31:24], 1'b0, 1'b0);
            if (k > 0) chk("rate_drop", 32'(bus.out_valid), 32'd0);
            drive(1'b1, 1'b0, f[23:16], 1'b0, 1'b0);
            drive(1'b1, 1'b0, f[15:8],  1'b0, 1'b0);
            sb.push_back(f);
            drive(1'b1, 1'b0, f[7:0],   1'b0, 1'b0);
            chk("rate_valid", 32'(bus.out_valid), 32'd1);
        end
        idle();

        // Drain and load on the same edge: no bubble
        bus.out_ready = 1'b0;
        send_frame(32'hD1D2D3D4, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hE3, 1'b0, 1'b0);
        chk("d_l_held", outs(), 32'hD1D2D3D4);
        bus.out_ready = 1'b1;
        sb.push_back(32'hE1E2E3E4);
        drive(1'b1, 1'b0, 8'hE4, 1'b0, 1'b0);
        chk("d_l_valid", 32'(bus.out_valid), 32'd1);
        chk("d_l_data", outs(), 32'hE1E2E3E4);
        idle();
        chk("d_l_drop", 32'(bus.out_valid), 32'd0);

        // Reset mid-frame with a presented frame pending
        bus.out_ready = 1'b0;
        send_frame(32'hF1F2F3F4, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
        chk("pre_rst_slot", 32'(slot), 32'd2);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_outs", outs(), 32'd0);
        chk("mid_rst_slot", 32'(slot), 32'd0);
`ifdef DEMUX_ERR_CNT_EN
        exp_cnt = 0;
        chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        chk("post_rst_hunt", 32'(slot), 32'd0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        send_frame(32'h12345678, 1'b1, 1'b0);
        chk("post_rst_frame", outs(), 32'h12345678);
        idle();
        chk("post_rst_drop", 32'(bus.out_valid), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
